// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter peripheral.
//   tx_state_t   : transmit FSM state encoding
//   DATA_OFS     : byte offset of the write-only DATA register
//   STAT_OFS     : byte offset of the STATUS register
//   STAT_*       : bit positions of the fields inside STATUS
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic [3:0] DATA_OFS = 4'h0;
  localparam logic [3:0] STAT_OFS = 4'h4;

  localparam int STAT_ACTIVE  = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;
  localparam int STAT_CNT_W   = 5;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through output.
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset (pointers and count only)
//   push  : write din; ignored while full
//   pop   : advance read pointer; ignored while empty
//   din   : write data
//   dout  : data at the head of the FIFO, valid whenever empty is low
//   full  : count == DEPTH
//   empty : count == 0
//   count : number of stored entries
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter on the CPU I/O bus.
//   clk       : system clock
//   rst       : asynchronous active-low reset
//   cs        : device select
//   mem_write : store strobe, qualified by cs
//   addr      : byte offset (0x0 DATA, 0x4 STATUS)
//   wdata     : store data
//   rdata     : combinational read data for addr
//   tx        : serial output, idle high, registered
//   busy      : frame in progress or FIFO non-empty
//
// state | meaning
// IDLE  | line high, waiting for a byte in the FIFO
// START | start bit (low) for one bit period
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high); chains straight into START if more data
module uart_tx_periph
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        mem_write,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  busy
);

  localparam int DIV   = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CNT_W = $clog2(DIV);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DIV_M1 = CNT_W'(DIV - 1);

  tx_state_t        state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             ovf_q, ovf_d;

  logic             wr_data, wr_stat, baud_end, tx_active;
  logic             fifo_pop, fifo_full, fifo_empty;
  logic [7:0]       fifo_dout;
  logic [CW-1:0]    fifo_count;
  logic             unused_wdata;

  assign unused_wdata = ^wdata[31:8];

  assign wr_data  = cs & mem_write & (addr == DATA_OFS);
  assign wr_stat  = cs & mem_write & (addr == STAT_OFS);
  assign baud_end = (baud_q == DIV_M1);

  // The FIFO itself drops pushes while full, so the raw strobe is passed in.
  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (wr_data),
    .pop  (fifo_pop),
    .din  (wdata[7:0]),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  // A dropped write sets overflow regardless of a same-cycle pop.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_data && fifo_full)       ovf_d = 1'b1;
    else if (wr_stat && wdata[3])   ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = START;
      START:   if (baud_end) state_d = DATA;
      DATA:    if (baud_end && bit_q == 3'd7) state_d = STOP;
      STOP:    if (baud_end) state_d = fifo_empty ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fifo_pop = 1'b0;
    baud_d   = baud_end ? '0 : baud_q + CNT_W'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
        end
      end
      START: if (baud_end) bit_d = 3'd0;
      DATA: begin
        if (baud_end) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
        end
      end
      STOP: begin
        if (baud_end && !fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
        end
      end
      default: baud_d = '0;
    endcase

    // tx is registered from the next state so it changes exactly on the
    // edge where the state does.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx_active = (state_q != IDLE);
  assign tx        = tx_q;
  assign busy      = tx_active | ~fifo_empty;

  always_comb begin
    rdata = '0;
    if (addr == STAT_OFS) begin
      rdata[STAT_ACTIVE] = tx_active;
      rdata[STAT_FULL]   = fifo_full;
      rdata[STAT_EMPTY]  = fifo_empty;
      rdata[STAT_OVF]    = ovf_q;
      rdata[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(fifo_count);
    end
  end

endmodule

// File: doc/uart_tx_periph.md
Name: uart_tx_periph

Overview:
Memory-mapped UART transmitter on the CPU I/O bus, alongside the LED, switch and seven-segment devices.
- Takes CPU store data through the same chip-select, write-strobe, address and store-data signals that feed the I/O device unit.
- Buffers bytes in a small FIFO and serialises them as 8N1 frames on one tx pin.
- Returns a status word on the read-data path for CPU polling.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s. Bit period DIV = (CLK_HZ + BAUD/2) / BAUD, computed at elaboration; DIV must be >= 2.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..16.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cs  in  1  device select, decoded upstream from alu_result.
- mem_write  in  1  store strobe, qualified by cs.
- addr  in  4  byte offset; alu_result[3:0].
- wdata  in  32  store data (reg_data_2); only [7:0] used for DATA.
- rdata  out  32  combinational read data for the current addr.
- tx  out  1  serial output; idle high.
- busy  out  1  high while a frame is shifting or the FIFO is non-empty.

Behaviour:
- Register map:
  - 0x0 DATA, write-only: cs & mem_write pushes wdata[7:0]. Reads return 0.
  - 0x4 STATUS. Read: bit0 tx_active, bit1 fifo_full, bit2 fifo_empty, bit3 overflow (sticky), bits[8:4] fifo_count, others 0. Write with wdata[3]=1 clears overflow; other bits are ignored.
  - Any other offset: reads return 0, writes are ignored.
- rdata is combinational: it is valid in the same cycle as addr and does not depend on cs.
- Reset values (rst low, asynchronous): tx=1, busy=0, FIFO empty, count=0, overflow=0, FSM=IDLE, baud counter=0, bit index=0. Reset mid-frame aborts the frame; tx goes high immediately.
- Push rule:
  - Full is evaluated from the registered count.
  - A write while full is dropped and sets overflow, even if a pop happens in the same cycle.
  - Push and pop in the same non-full cycle leaves count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO not empty, pop into an 8-bit shift register, clear the baud counter, go to START.
  - START: tx=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] (LSB first) for DIV cycles per bit. Shift right after each bit. After bit 7, go to STOP.
  - STOP: tx=1 for DIV cycles. At the end, if the FIFO is not empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Baud counter:
  - Counts 0..DIV-1 and wraps; state advances on the cycle the counter equals DIV-1.
  - Width is $clog2(DIV).
- tx is a registered output (glitch-free).
- Latency:
  - Write accepted in cycle N → count updates at the end of N → IDLE pops in N+1 → tx low from N+2.
  - Frame length is exactly 10*DIV cycles.
- tx_active is high in START, DATA and STOP. busy = tx_active | ~fifo_empty.
- FIFO count width is $clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.

Decomposition:
- uart_pkg holds:
  - tx_state_t enum (IDLE, START, DATA, STOP);
  - register offsets DATA_OFS=4'h0 and STAT_OFS=4'h4;
  - STATUS bit-position constants.
- sub-module sync_fifo, parameterised by WIDTH and DEPTH, with ports push/pop/din/dout/full/empty/count. It has first-word-fall-through dout and the same clk/rst convention.
- The top of the block holds the register decode, the FSM, the baud counter and the overflow flag.

Test Plan:
All scenarios use CLK_HZ=16, BAUD=1, so DIV=16.
- Reset: hold rst=0 for 5 cycles, then release → tx=1, busy=0, STATUS read at 0x4 returns 0x00000004.
- Single byte: write 0x55 to 0x0 in cycle N → tx=0 from N+2. The tx sequence is 0,1,0,1,0,1,0,1,0,1, each level held 16 cycles. busy falls at N+162.
- Back-to-back: write 0xA3 and 0x0F in consecutive cycles → two 160-cycle frames with no idle gap. Data bits are 1,1,0,0,0,1,0,1 then 1,1,1,1,0,0,0,0.
- Overflow: write 10 bytes in 10 consecutive cycles → 9 are accepted (1 popped, 8 buffered) and the 10th is dropped. STATUS reads bit3=1, bit1=1, count=8. Writing 0x8 to 0x4 clears bit3 only.
- Reset mid-frame: write 0xFF, then pull rst low during DATA bit 3 → tx=1 in the same cycle. After release, STATUS=0x4 and no further frame is sent.
- Decode: write 0x12 to offset 0x8, and write with cs=0 → no frame and count stays 0. A read at 0x0 returns 0.
